// File: rtl/ofmap_postproc_stream_if.sv
// Valid/ready beat stream with tile framing, used for both the psum
// input side and the activation output side of the ofmap post-processor.
interface ofmap_postproc_stream_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/ofmap_postproc_stream.sv
// Ofmap drain post-processor: per-lane saturating truncate, optional ReLU,
// optional 2x2/stride-2 max pool through a half-width line buffer.
module ofmap_postproc_stream #(
  parameter int LANES    = 8,
  parameter int WD       = 8,
  parameter int FI       = 3,
  parameter int MAX_COLS = 32,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_relu,
  input  logic          cfg_pool,
  input  logic [CW-1:0] cfg_cols,
  ofmap_postproc_stream_if.slave  s,
  ofmap_postproc_stream_if.master m,
  output logic          err
);
  localparam int PW  = 2 * WD;
  localparam int DW  = LANES * WD;
  localparam int LBD = MAX_COLS / 2;
  localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;

  localparam logic signed [PW-1:0] PMAX =
    {{(WD+1){1'b0}}, {(WD-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN =
    {{(WD+1){1'b1}}, {(WD-1){1'b0}}};
  localparam logic [WD-1:0] WMAX = {1'b0, {(WD-1){1'b1}}};
  localparam logic [WD-1:0] WMIN = {1'b1, {(WD-1){1'b0}}};

  typedef enum logic {ROW_EVEN, ROW_ODD} row_e;

  row_e          state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] cols_q, cols_d;
  logic          mid_q, mid_d;
  logic          relu_q, relu_d;
  logic          pool_q, pool_d;
  logic [DW-1:0] h_q, h_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          err_q, err_d;

  logic [DW-1:0] lb_q [LBD];
  logic          lb_we;
  logic [LBW-1:0] lb_idx;
  logic [DW-1:0] lb_rd, lb_wd;
  logic [DW-1:0] v_vec, pool_vec;

  logic          e_relu, e_pool;
  logic [CW-1:0] e_cols;
  logic          accept, emit, bad, end_col;

  function automatic logic [WD-1:0] sat(input logic [PW-1:0] p);
    logic signed [PW-1:0] y;
    y = $signed(p) >>> FI;
    if (y > PMAX) return WMAX;
    if (y < PMIN) return WMIN;
    return y[WD-1:0];
  endfunction

  function automatic logic [WD-1:0] smax(
    input logic [WD-1:0] a,
    input logic [WD-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign s.ready = ~m_valid_q | m.ready;
  assign accept  = s.valid & s.ready;
  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.last  = m_last_q;
  assign err     = err_q;

  // Live config on the first beat of a tile, latched copy afterwards.
  assign e_relu  = mid_q ? relu_q : cfg_relu;
  assign e_pool  = mid_q ? pool_q : cfg_pool;
  assign e_cols  = mid_q ? cols_q : cfg_cols;
  assign end_col = (col_q == e_cols - CW'(1));
  assign emit    = ~e_pool | ((state_q == ROW_ODD) & col_q[0]);
  assign bad     = s.last & (e_pool
                 ? ~((state_q == ROW_ODD) & col_q[0])
                 : ~end_col);

  assign lb_idx = LBW'(col_q >> 1);
  assign lb_rd  = lb_q[lb_idx];

  always_comb begin
    logic [WD-1:0] a;
    logic [WD-1:0] hm;
    a        = '0;
    hm       = '0;
    v_vec    = '0;
    lb_wd    = '0;
    pool_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      a = sat(s.data[k*PW +: PW]);
      if (e_relu && a[WD-1]) a = '0;
      hm = smax(h_q[k*WD +: WD], a);
      v_vec[k*WD +: WD]    = a;
      lb_wd[k*WD +: WD]    = hm;
      pool_vec[k*WD +: WD] = smax(lb_rd[k*WD +: WD], hm);
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cols_d    = cols_q;
    mid_d     = mid_q;
    relu_d    = relu_q;
    pool_d    = pool_q;
    h_d       = h_q;
    m_valid_d = m_valid_q & ~m.ready;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    err_d     = err_q;
    lb_we     = 1'b0;
    if (accept) begin
      if (!mid_q) begin
        relu_d = cfg_relu;
        pool_d = cfg_pool;
        cols_d = cfg_cols;
      end
      mid_d = 1'b1;
      if (e_pool && !col_q[0]) h_d = v_vec;
      lb_we = e_pool & col_q[0] & (state_q == ROW_EVEN);
      if (emit) begin
        m_valid_d = 1'b1;
        m_data_d  = e_pool ? pool_vec : v_vec;
        m_last_d  = s.last;
      end
      if (s.last) begin
        col_d   = '0;
        state_d = ROW_EVEN;
        mid_d   = 1'b0;
        err_d   = err_q | bad;
      end else if (end_col) begin
        col_d   = '0;
        state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ROW_EVEN;
      col_q     <= '0;
      cols_q    <= '0;
      mid_q     <= 1'b0;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      h_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cols_q    <= cols_d;
      mid_q     <= mid_d;
      relu_q    <= relu_d;
      pool_q    <= pool_d;
      h_q       <= h_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  // Written on every even-row pair before the odd row reads it back.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_idx] <= lb_wd;
  end
endmodule

// File: tb/tb_ofmap_postproc_stream.sv
// Directed bench for ofmap_postproc_stream: vector table, pooling tiles,
// backpressure with a random stream, framing error and mid-tile reset.
module tb_ofmap_postproc_stream;
  localparam int LANES    = 4;
  localparam int WD       = 8;
  localparam int FI       = 3;
  localparam int MAX_COLS = 32;
  localparam int CW       = 6;
  localparam int PW       = 2 * WD;
  localparam int SW       = LANES * PW;
  localparam int DW       = LANES * WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_relu = 1'b0;
  logic          cfg_pool = 1'b0;
  logic [CW-1:0] cfg_cols = CW'(2);
  logic          err;

  ofmap_postproc_stream_if #(.W(SW)) s_if ();
  ofmap_postproc_stream_if #(.W(DW)) m_if ();

  ofmap_postproc_stream #(
    .LANES(LANES), .WD(WD), .FI(FI),
    .MAX_COLS(MAX_COLS), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_relu(cfg_relu),
    .cfg_pool(cfg_pool),
    .cfg_cols(cfg_cols),
    .s(s_if),
    .m(m_if),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } out_t;

  out_t got[$];
  out_t expq[$];

  always @(negedge clk) begin
    if (!rst && m_if.valid && m_if.ready)
      got.push_back({m_if.data, m_if.last});
  end

  typedef struct packed {
    logic          relu;
    logic [SW-1:0] p;
    logic [DW-1:0] e;
  } vec_t;

  vec_t vecs[5];

  int ta0[4] = '{1, 5, 2, 3};
  int ta1[4] = '{4, 0, 9, 1};
  int tb0[4] = '{-3, 7, 2, 2};
  int tb1[4] = '{6, -8, 0, 11};

  bit stop = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WD-1:0] ref_act(input logic [PW-1:0] p,
                                            input bit relu);
    int y;
    y = int'($signed(p));
    y = y >>> FI;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    if (relu && y < 0) y = 0;
    return WD'(y);
  endfunction

  function automatic int lv(input int val, input int k);
    case (k)
      0:       return val;
      1:       return -val;
      2:       return 3 * val;
      default: return val - 5;
    endcase
  endfunction

  function automatic logic [SW-1:0] mk_beat(input int val);
    logic [SW-1:0] b;
    b = '0;
    for (int k = 0; k < LANES; k++)
      b[k*PW +: PW] = PW'(lv(val, k) * 8);
    return b;
  endfunction

  function automatic logic [DW-1:0] pool_exp(input int r0[4],
                                             input int r1[4],
                                             input int j);
    logic [DW-1:0] o;
    int vals[4];
    int mx, a;
    o = '0;
    vals[0] = r0[2*j];
    vals[1] = r0[2*j+1];
    vals[2] = r1[2*j];
    vals[3] = r1[2*j+1];
    for (int k = 0; k < LANES; k++) begin
      mx = -1000;
      for (int q = 0; q < 4; q++) begin
        a = int'($signed(ref_act(PW'(lv(vals[q], k) * 8), 1'b0)));
        if (a > mx) mx = a;
      end
      o[k*WD +: WD] = WD'(mx);
    end
    return o;
  endfunction

  task automatic send_beat(input logic [SW-1:0] d, input logic l);
    bit ok;
    int n;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_if.ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_beat: accepted %0d required 1", ok);
    end
  endtask

  task automatic run_tile(input int r0[4], input int r1[4],
                          input string nm);
    got.delete();
    for (int b = 0; b < 8; b++)
      send_beat(mk_beat(b < 4 ? r0[b] : r1[b-4]), b == 7);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_count"}, 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk({nm, "_d0"}, 64'(got[0].d), 64'(pool_exp(r0, r1, 0)));
      chk({nm, "_l0"}, 64'(got[0].l), 64'd0);
      chk({nm, "_d1"}, 64'(got[1].d), 64'(pool_exp(r0, r1, 1)));
      chk({nm, "_l1"}, 64'(got[1].l), 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] d;
    logic [DW-1:0] e;
    bit trelu;
    int n;

    vecs[0] = '{1'b0,
      {16'hFFF8, 16'h8000, 16'h7FFF, 16'h0050},
      {8'hFF, 8'h80, 8'h7F, 8'h0A}};
    vecs[1] = '{1'b1,
      {16'hFFF8, 16'h8000, 16'h7FFF, 16'h0050},
      {8'h00, 8'h00, 8'h7F, 8'h0A}};
    vecs[2] = '{1'b0,
      {16'hFBF8, 16'hFC00, 16'h0400, 16'h03F8},
      {8'h80, 8'h80, 8'h7F, 8'h7F}};
    vecs[3] = '{1'b0,
      {16'h0008, 16'hFFF0, 16'hFFFF, 16'h0007},
      {8'h01, 8'hFE, 8'hFF, 8'h00}};
    vecs[4] = '{1'b1,
      {16'h0008, 16'h03F8, 16'hFFFF, 16'h0007},
      {8'h01, 8'h7F, 8'h00, 8'h00}};

    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_if.ready), 64'd1);
    chk("rst_m_valid", 64'(m_if.valid), 64'd0);
    chk("rst_m_data", 64'(m_if.data), 64'd0);
    chk("rst_m_last", 64'(m_if.last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // Two-beat tiles; flipping relu on beat 2 must have no effect.
    cfg_pool = 1'b0;
    cfg_cols = CW'(2);
    for (int i = 0; i < 5; i++) begin
      cfg_relu   = vecs[i].relu;
      s_if.valid = 1'b1;
      s_if.data  = vecs[i].p;
      s_if.last  = 1'b0;
      @(posedge clk);
      #1;
      chk("vec_valid", 64'(m_if.valid), 64'd1);
      chk("vec_data0", 64'(m_if.data), 64'(vecs[i].e));
      chk("vec_last0", 64'(m_if.last), 64'd0);
      cfg_relu  = ~vecs[i].relu;
      s_if.last = 1'b1;
      @(posedge clk);
      #1;
      chk("vec_data1", 64'(m_if.data), 64'(vecs[i].e));
      chk("vec_last1", 64'(m_if.last), 64'd1);
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    @(posedge clk);
    #1;
    chk("vec_idle_valid", 64'(m_if.valid), 64'd0);
    chk("vec_err", 64'(err), 64'd0);

    // Backpressure then 64-beat random stream against the model.
    cfg_cols = CW'(8);
    got.delete();
    expq.delete();
    trelu = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 0) begin
        trelu    = 1'($urandom % 2);
        cfg_relu = trelu;
      end
      d = {$urandom(), $urandom()};
      send_beat(d, (i % 8) == 7);
      e = '0;
      for (int k = 0; k < LANES; k++)
        e[k*WD +: WD] = ref_act(d[k*PW +: PW], trelu);
      expq.push_back({e, 1'b0});
      if (i == 0) begin
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        chk("bp_valid", 64'(m_if.valid), 64'd1);
        repeat (5) begin
          @(posedge clk);
          #1;
          chk("bp_s_ready", 64'(s_if.ready), 64'd0);
          chk("bp_hold", 64'(m_if.data), 64'(e));
        end
        m_if.ready = 1'b1;
        fork
          while (!stop) begin
            @(posedge clk);
            #1;
            if (!stop) m_if.ready = ($urandom % 3) != 0;
          end
        join_none
      end else if ($urandom % 4 == 0) begin
        s_if.valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    for (int j = 7; j < 64; j += 8) expq[j].l = 1'b1;
    stop       = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    n = 0;
    while (got.size() < 64 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("rand_count", 64'(got.size()), 64'd64);
    for (int j = 0; j < 64 && j < got.size(); j++) begin
      chk("rand_data", 64'(got[j].d), 64'(expq[j].d));
      chk("rand_last", 64'(got[j].l), 64'(expq[j].l));
    end
    chk("rand_err", 64'(err), 64'd0);

    cfg_pool = 1'b1;
    cfg_relu = 1'b0;
    cfg_cols = CW'(4);
    run_tile(ta0, ta1, "poolA");
    chk("poolA_err", 64'(err), 64'd0);

    // Early s_last on the first row: error, no output.
    got.delete();
    send_beat(mk_beat(2), 1'b0);
    send_beat(mk_beat(3), 1'b1);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frm_err", 64'(err), 64'd1);
    chk("frm_nout", 64'(got.size()), 64'd0);
    run_tile(tb0, tb1, "poolB");
    chk("poolB_err", 64'(err), 64'd1);

    // Reset while an odd-row pooled output is stalled downstream.
    got.delete();
    for (int b = 0; b < 6; b++)
      send_beat(mk_beat(b < 4 ? ta0[b] : ta1[b-4]), 1'b0);
    m_if.ready = 1'b0;
    s_if.valid = 1'b0;
    chk("mr_pre_valid", 64'(m_if.valid), 64'd1);
    chk("mr_pre_data", 64'(m_if.data), 64'(pool_exp(ta0, ta1, 0)));
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(m_if.valid), 64'd0);
    chk("mr_data", 64'(m_if.data), 64'd0);
    chk("mr_last", 64'(m_if.last), 64'd0);
    chk("mr_err", 64'(err), 64'd0);
    chk("mr_s_ready", 64'(s_if.ready), 64'd1);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    m_if.ready = 1'b1;
    run_tile(tb1, ta1, "poolR");
    chk("poolR_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ofmap_postproc_stream.md
# ofmap_postproc_stream

Parametrised streaming post-processor for the ofmap drain path of the LeNet-5 systolic accelerator. Accepts one beat of LANES partial sums (2·WD-bit fixed point) per cycle, truncates with saturation to WD bits, applies optional ReLU and optional 2x2/stride-2 max pooling, and emits WD-bit activations over a valid/ready stream. It generalises the fixed 8-lane truncate/ReLU/pool path to arbitrary lane count, width and tile width, and adds a line buffer, backpressure and tile framing.

## Interface
- LANES, 8, output channels per beat
- WD, 8, activation width; psum width is 2·WD
- FI, 3, psum fraction bits dropped by truncation (FI ≤ WD)
- MAX_COLS, 32, max tile width in pixels (even); sets line-buffer depth MAX_COLS/2
- CW, 6, column/cfg_cols counter width (≥ clog2(MAX_COLS)+1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_relu  in  1  enable ReLU
- cfg_pool  in  1  enable 2x2 max pool
- cfg_cols  in  CW  tile width in pixels, 2..MAX_COLS; even when cfg_pool=1
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_psum  in  LANES·2·WD  signed psums, lane k at [k·2WD +: 2WD]
- s_last  in  1  final beat of tile
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  LANES·WD  activations, lane k at [k·WD +: WD]
- m_last  out  1  final output of tile
- err  out  1  sticky framing error

## Operation
- Config sampled into registers on the first accepted beat of each tile (col=0,row=0); changes mid-tile are ignored.
- Truncate per lane: y = psum >>> FI (arithmetic, floor). If y > 2^(WD-1)−1 → 2^(WD-1)−1; if y < −2^(WD-1) → −2^(WD-1); else y[WD-1:0].
- ReLU (cfg_relu=1): negative results → 0. Applied after saturation, before pooling.
- Counters: col 0..cfg_cols−1, row toggles parity (ROW_EVEN / ROW_ODD state); col wraps to 0 and state toggles at col=cfg_cols−1.
- Pool off: every accepted beat produces one output; m_last = s_last of that beat.
- Pool on, per lane signed max:
  - even col: hold value in h_reg.
  - odd col, ROW_EVEN: line_buf[col/2] ← max(h_reg, v); no output.
  - odd col, ROW_ODD: output max(line_buf[col/2], h_reg, v).
  - m_last set iff s_last arrives on (ROW_ODD, odd col).
- s_last: after processing, col←0, state←ROW_EVEN, cfg re-sampled next beat.
- Framing error: s_last with pool on at any position other than (ROW_ODD, odd col), or s_last with pool off at col≠cfg_cols−1: err←1 (sticky until rst), the beat produces no output (pool on) or normal output with m_last=1 (pool off); counters reset as for s_last.
- Line buffer contents are not cleared between tiles; always written before read.

## Timing
- Reset values: s_ready=1, m_valid=0, m_data=0, m_last=0, err=0, col=0, state=ROW_EVEN, h_reg=0.
- s_ready = ~m_valid | m_ready (combinational from m_ready only).
- Single registered output stage: beat accepted at edge t → m_valid=1 from t+1 (pool off, or emitting pool beat).
- m_valid/m_data/m_last held stable while m_valid & ~m_ready.
- Full throughput: one beat per cycle while m_ready=1.
- Non-emitting pool beats accepted under same s_ready rule; they do not set m_valid, and an existing output is cleared if m_ready accepts it.
- rst mid-tile: all counters, output, err cleared immediately; partial pool state discarded.

## Test plan
- WD=8,FI=3, pool off, relu off: psum lanes 0x0050, 0x7FFF, 0x8000, 0xFFF8 → m_data lanes 0x0A, 0x7F, 0x80, 0xFF one cycle after accept.
- Same with relu on → 0x0A, 0x7F, 0x00, 0x00.
- Pool on, cfg_cols=4, 2 rows, lane0 values (row0) 1,5,2,3 (row1) 4,0,9,1 (all psum<<3), s_last on 8th beat → exactly two outputs 5, 9; m_last on second; err=0.
- Backpressure: m_ready=0 for 5 cycles with m_valid=1 → s_ready=0, m_data stable; release → stream resumes, no beat lost or duplicated over 64-beat random run vs. model.
- s_last at col=1 of ROW_EVEN with pool on → err=1, no output; next tile of 4x2 produces correct results, err stays 1.
- Assert rst during row 1 of pooled tile → all outputs 0 next edge; subsequent full tile output matches model.
